cdb_sched: RTL and testbench

Writeback scheduler between the six functional-unit result ports (alu0, alu1, alu2, mul, mem, bcond) and the N_WAY-lane common data bus. Each FU result is buffered in a small per-FU queue with a valid/ready handshake. Up to N_WAY queue heads per cycle are granted onto CDB lanes in round-robin order. FUs stall through backpressure instead of overflowing the bus. Downstream consumers (PRF write, RS wakeup, ROB complete) see packed, lane-ordered results.

---
 rtl/cdb_sched.sv | 113 +++++++++++
 tb/tb_cdb_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_sched.sv
// Writeback scheduler: per-FU result queues feeding an N_WAY-lane common data bus.
// Up to N_WAY non-empty queue heads are granted per cycle in round-robin order onto packed lanes.
module cdb_sched #(
  parameter int N_REQ  = 6,
  parameter int N_WAY  = 3,
  parameter int DATA_W = 112,
  parameter int DEPTH  = 2,
  parameter int SRC_W  = 3
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_WAY-1:0]          lane_valid,
  output logic [N_WAY*DATA_W-1:0]   lane_data,
  output logic [N_WAY*SRC_W-1:0]    lane_src,
  output logic [N_REQ*2-1:0]        occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q  [N_REQ][DEPTH];
  logic [PTR_W-1:0]  head_q [N_REQ];
  logic [PTR_W-1:0]  tail_q [N_REQ];
  logic [CNT_W-1:0]  cnt_q  [N_REQ];
  logic [SRC_W-1:0]  rr_q, rr_d;

  logic [N_REQ-1:0]  push;
  logic [N_REQ-1:0]  gnt;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i]    = (cnt_q[i] < CNT_W'(DEPTH));
      push[i]         = req_valid[i] & req_ready[i] & ~flush;
      occ[i*2 +: 2]   = 2'(cnt_q[i]);
    end
  end

  // Round-robin scan from rr_q; grants fill lanes in scan order, so lanes stay packed.
  always_comb begin
    int n;
    int idx;
    int nxt;
    gnt        = '0;
    lane_valid = '0;
    lane_data  = '0;
    lane_src   = '0;
    rr_d       = rr_q;
    n          = 0;
    idx        = 0;
    nxt        = 0;
    if (!flush) begin
      for (int j = 0; j < N_REQ; j++) begin
        idx = int'(rr_q) + j;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (cnt_q[idx] != '0 && n < N_WAY) begin
          gnt[idx]                       = 1'b1;
          lane_valid[n]                  = 1'b1;
          lane_data[n*DATA_W +: DATA_W]  = mem_q[idx][head_q[idx]];
          lane_src[n*SRC_W +: SRC_W]     = SRC_W'(idx);
          nxt                            = (idx == N_REQ - 1) ? 0 : idx + 1;
          rr_d                           = SRC_W'(nxt);
          n                              = n + 1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (push[i]) mem_q[i][tail_q[i]] <= req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < N_REQ; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < N_REQ; i++) begin
        if (push[i]) tail_q[i] <= PTR_W'(tail_q[i] + 1'b1);
        if (gnt[i])  head_q[i] <= PTR_W'(head_q[i] + 1'b1);
        if (push[i] && !gnt[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (!push[i] && gnt[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        assert (!(push[i] && cnt_q[i] == CNT_W'(DEPTH)));
      end
      assert ($countones(lane_valid) <= N_WAY);
      assert ((lane_valid & (lane_valid + 1'b1)) == '0);
    end
  end

endmodule

// File: tb/tb_cdb_sched.sv
// Randomized bench for cdb_sched against a queue-based reference model of the writeback rules.
module tb_cdb_sched;
  localparam int N_REQ  = 6;
  localparam int N_WAY  = 3;
  localparam int DATA_W = 112;
  localparam int DEPTH  = 2;
  localparam int SRC_W  = 3;

  typedef int cnt_t [N_REQ];

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic                    flush;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [N_WAY-1:0]        lane_valid;
  logic [N_WAY*DATA_W-1:0] lane_data;
  logic [N_WAY*SRC_W-1:0]  lane_src;
  logic [N_REQ*2-1:0]      occ;

  cdb_sched dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .lane_valid(lane_valid), .lane_data(lane_data), .lane_src(lane_src), .occ(occ)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mq [N_REQ][$];
  int                rr_m;
  int                gnt_m [$];
  logic [N_REQ-1:0]  acc_m;

  logic [N_REQ-1:0]  pv;
  logic [DATA_W-1:0] pd [N_REQ];
  int                seq [N_REQ];

  bit   ovl_rec = 1'b0;
  bit   saw_rdy_low = 1'b0;
  cnt_t hist [$];

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N_WAY-1:0]        ev;
    logic [N_WAY*DATA_W-1:0] ed;
    logic [N_WAY*SRC_W-1:0]  es;
    logic [N_REQ-1:0]        er;
    logic [N_REQ*2-1:0]      eo;
    cnt_t                    h;
    int                      i;
    int                      k;
    ev = '0; ed = '0; es = '0;
    gnt_m.delete();
    if (!flush) begin
      for (int j = 0; j < N_REQ; j++) begin
        i = (rr_m + j) % N_REQ;
        if (mq[i].size() > 0 && gnt_m.size() < N_WAY) begin
          k = gnt_m.size();
          ev[k] = 1'b1;
          ed[k*DATA_W +: DATA_W] = mq[i][0];
          es[k*SRC_W +: SRC_W]   = SRC_W'(i);
          gnt_m.push_back(i);
        end
      end
    end
    for (int q = 0; q < N_REQ; q++) begin
      er[q]         = (mq[q].size() < DEPTH);
      eo[q*2 +: 2]  = 2'(mq[q].size());
    end
    chk("lane_valid", 384'(lane_valid), 384'(ev));
    chk("lane_data",  384'(lane_data),  384'(ed));
    chk("lane_src",   384'(lane_src),   384'(es));
    chk("req_ready",  384'(req_ready),  384'(er));
    chk("occ",        384'(occ),        384'(eo));
    if (ovl_rec) begin
      h = '{default: 0};
      for (int l = 0; l < N_WAY; l++)
        if (lane_valid[l]) h[int'(lane_src[l*SRC_W +: SRC_W])]++;
      hist.push_back(h);
      if (req_ready != '1) saw_rdy_low = 1'b1;
    end
  endtask

  task automatic model_update();
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) mq[i].delete();
      rr_m = 0;
      acc_m = '0;
    end else if (flush) begin
      for (int i = 0; i < N_REQ; i++) mq[i].delete();
      acc_m = '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) acc_m[i] = req_valid[i] && (mq[i].size() < DEPTH);
      foreach (gnt_m[g]) void'(mq[gnt_m[g]].pop_front());
      if (gnt_m.size() > 0) rr_m = (gnt_m[gnt_m.size()-1] + 1) % N_REQ;
      for (int i = 0; i < N_REQ; i++)
        if (acc_m[i]) mq[i].push_back(req_data[i*DATA_W +: DATA_W]);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush   = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_valid = N_REQ'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom};
      tick();
    end
    reset_n   = 1'b1;
    req_valid = '0;
    req_data  = '0;
    pv        = '0;
  endtask

  // FU-side driver: a result is offered until accepted, then a new tagged one may follow.
  task automatic drive(input int pct, input int flush_pct, input int rst_per);
    logic [127:0] r;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pv[i] && $urandom_range(99) < pct) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        pv[i] = 1'b1;
        pd[i] = r[DATA_W-1:0];
        pd[i][15:0] = 16'(i * 4096 + (seq[i] % 4096));
        seq[i]++;
      end
      req_data[i*DATA_W +: DATA_W] = pd[i];
    end
    req_valid = pv;
    flush     = ($urandom_range(99) < flush_pct);
    reset_n   = (rst_per == 0) ? 1'b1 : ($urandom_range(rst_per - 1) != 0);
    tick();
    if (!reset_n || flush) pv = '0;
    else pv = pv & ~acc_m;
  endtask

  initial begin
    int maxd;
    int mn;
    int mx;
    int s;
    bit saw77;

    reset_n = 1'b0; flush = 1'b0; req_valid = '0; req_data = '0; pv = '0;
    for (int i = 0; i < N_REQ; i++) begin pd[i] = '0; seq[i] = 0; end
    @(posedge clock);
    model_update();
    #1;

    // Reset with random requests, then nothing stale after release
    do_reset();
    chk("rst_ready", 384'(req_ready), 384'(6'b111111));
    chk("rst_occ",   384'(occ),       384'(0));
    tick();
    chk("rst_lanes", 384'(lane_valid), 384'(0));

    // Single result from FU2
    req_valid = 6'b000100;
    req_data  = '0;
    req_data[2*DATA_W +: DATA_W] = 112'hA5;
    tick();
    req_valid = '0;
    chk("t2_valid", 384'(lane_valid), 384'(3'b001));
    chk("t2_data",  384'(lane_data[DATA_W-1:0]), 384'(112'hA5));
    chk("t2_src",   384'(lane_src[SRC_W-1:0]), 384'(3'd2));
    tick();
    chk("t2_empty", 384'(lane_valid), 384'(0));
    // rr is now 3: FU0 and FU4 both pending, FU4 must take lane 0
    req_valid = 6'b010001;
    req_data[0 +: DATA_W]        = 112'h10;
    req_data[4*DATA_W +: DATA_W] = 112'h14;
    tick();
    req_valid = '0;
    chk("t2_rr_order", 384'(lane_src[2*SRC_W-1:0]), 384'({3'd0, 3'd4}));
    tick();

    // Full burst from rr_ptr 0
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'(i);
    tick();
    req_valid = '0;
    chk("t3_first",  384'(lane_src), 384'({3'd2, 3'd1, 3'd0}));
    tick();
    chk("t3_second", 384'(lane_src), 384'({3'd5, 3'd4, 3'd3}));
    chk("t3_data",   384'(lane_data), 384'({112'd5, 112'd4, 112'd3}));
    tick();
    chk("t3_drained", 384'(lane_valid), 384'(0));

    // Sustained overload
    do_reset();
    ovl_rec = 1'b1;
    for (int c = 0; c < 50; c++) drive(100, 0, 0);
    ovl_rec = 1'b0;
    maxd = 0;
    for (int w = 0; w + 6 <= hist.size(); w++) begin
      mn = 1000; mx = 0;
      for (int i = 0; i < N_REQ; i++) begin
        s = 0;
        for (int c = w; c < w + 6; c++) s += hist[c][i];
        if (s < mn) mn = s;
        if (s > mx) mx = s;
      end
      if (mx - mn > maxd) maxd = mx - mn;
    end
    chk("t4_fair", 384'(maxd <= 1), 384'(1));
    chk("t4_rdy_toggle", 384'(saw_rdy_low), 384'(1));
    pv = '0; req_valid = '0;
    for (int c = 0; c < 6; c++) tick();

    // Flush with queued results while FU1 offers 0x77
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'(8'h20 + i);
    tick();
    tick();
    flush     = 1'b1;
    req_valid = 6'b000010;
    req_data[1*DATA_W +: DATA_W] = 112'h77;
    @(negedge clock);
    chk("t5_lanes_flush", 384'(lane_valid), 384'(0));
    @(posedge clock);
    model_update();
    #1;
    flush = 1'b0;
    req_valid = '0;
    chk("t5_occ",   384'(occ),       384'(0));
    chk("t5_ready", 384'(req_ready), 384'(6'b111111));
    saw77 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < N_WAY; l++)
        if (lane_valid[l] && lane_data[l*DATA_W +: DATA_W] == 112'h77) saw77 = 1'b1;
      tick();
    end
    chk("t5_no77", 384'(saw77), 384'(0));

    // Simultaneous push and pop on FU4
    do_reset();
    req_valid = 6'b010000;
    req_data[4*DATA_W +: DATA_W] = 112'h44;
    tick();
    chk("t6_head", 384'(lane_data[DATA_W-1:0]), 384'(112'h44));
    req_data[4*DATA_W +: DATA_W] = 112'h55;
    tick();
    req_valid = '0;
    chk("t6_occ",  384'(occ[9:8]), 384'(2'd1));
    chk("t6_next", 384'(lane_data[DATA_W-1:0]), 384'(112'h55));
    tick();
    chk("t6_empty", 384'(lane_valid), 384'(0));

    // Random traffic with occasional flush and reset
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      int pct;
      pct = $urandom_range(100, 10);
      for (int c = 0; c < 60; c++) drive(pct, 3, 150);
    end
    pv = '0; req_valid = '0; flush = 1'b0; reset_n = 1'b1;
    for (int c = 0; c < 6; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
